viterbi_ctrl: RTL and testbench
===============================

Name: viterbi_ctrl

Overview:
- Frame-level sequencer for the K=3, rate-1/2 Viterbi decoder datapath.
- Accepts received 2-bit symbol pairs over a valid/ready handshake and registers each accepted symbol into the branch metric unit.
- Strobes the add-compare-select (ACS) stage and generates survivor-memory write addresses.
- At frame end, it hands over to traceback and waits for completion before accepting the next frame.

Parameters:
- SM_AW, 5, survivor memory address width; maximum frame length is 2^SM_AW symbols.
- LEN_W, SM_AW+1, width of symbol count and traceback length.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream symbol valid.
- in_ready  output  1  controller can accept a symbol this cycle.
- in_sym  input  2  received symbol pair {C0,C1}.
- in_last  input  1  qualifies the final symbol of the frame.
- bm_sym  output  2  registered symbol driven to the branch metric unit.
- pm_init  output  1  one-cycle pulse that resets path metrics (state 0 = 0, others = max).
- acs_en  output  1  ACS update strobe, aligned with bm_sym.
- sm_wr_addr  output  SM_AW  survivor memory write address, aligned with acs_en.
- tb_start  output  1  one-cycle traceback start pulse.
- tb_len  output  LEN_W  number of symbols in the frame, valid while tb_start is high.
- tb_addr  output  SM_AW  address of the last survivor write, valid while tb_start is high.
- tb_done  input  1  traceback-complete pulse.
- frame_done  output  1  one-cycle pulse when the frame completes.
- frame_err  output  1  sticky overflow flag; cleared on the pm_init of the next frame.

Behaviour:
- Reset: all outputs are 0 asynchronously and the FSM goes to IDLE. Reset asserted mid-frame aborts the frame; no tb_start is issued for it.
- FSM states: IDLE, INIT, RUN, DRAIN, TB, DONE.
- IDLE: in_ready=0. When in_valid=1, go to INIT. The symbol is not consumed; upstream must hold it.
- INIT: one cycle. pm_init=1, in_ready=0. Clear the symbol count and write pointer; clear frame_err. Go to RUN.
- RUN: in_ready=1. An accept is in_valid & in_ready.
  - On accept at cycle t: bm_sym<=in_sym at t+1, acs_en=1 at t+1, sm_wr_addr = write pointer at t+1.
  - The write pointer increments after each acs_en and wraps modulo 2^SM_AW. The symbol count increments per accept.
  - Back-to-back accepts give continuous acs_en; no bubble is inserted.
- Frame end: if the accepted symbol has in_last=1, go to DRAIN and drop in_ready from t+1.
- Overflow: if the accepted symbol is number 2^SM_AW and in_last=0, treat it as last. frame_err=1 from t+1, then go to DRAIN.
- DRAIN: one cycle; the last acs_en is issued here. Go to TB.
- TB: tb_start=1 for its first cycle only. tb_len = symbol count (1..2^SM_AW). tb_addr = last sm_wr_addr written. in_ready=0.
  - Wait for tb_done, then go to DONE. tb_done in the same cycle as tb_start is valid.
- DONE: frame_done=1 for one cycle, then go to IDLE.
- tb_done outside the TB state is ignored. in_last outside an accept is ignored.
- Latency: the tb_start rising edge occurs exactly 2 cycles after the accept of the last symbol.
- bm_sym holds its last value when acs_en=0.

Decomposition:
- Shared package viterbi_pkg holds:
  - K=3, NUM_STATES=4, SYM_W=2;
  - the ctrl_state_t enum (IDLE, INIT, RUN, DRAIN, TB, DONE);
  - PM_INIT_MAX.
- One natural sub-module, viterbi_sm_ptr: write pointer plus symbol counter, with clear/increment controls and wrap/overflow outputs. The FSM stays in viterbi_ctrl.

Test Plan:
- Single frame: 4 symbols 00,01,10,11 (last on 11), in_valid held high.
  - Required: pm_init 1 cycle, then acs_en for 4 consecutive cycles with sm_wr_addr 0..3 and bm_sym 00,01,10,11.
  - Required: tb_start 2 cycles after the last accept, with tb_len=4 and tb_addr=3.
  - Required: frame_done 1 cycle after tb_done.
- Gapped input: in_valid toggles 1,0,1,0,1 on 3 symbols.
  - Required: acs_en only on accepted symbols, sm_wr_addr 0,1,2, and tb_len=3.
- Overflow with SM_AW=2: 5 symbols sent, none with in_last.
  - Required: 4 accepted, frame_err=1, tb_len=4, tb_addr=3, and in_ready=0 when the 5th symbol is offered.
- Spurious tb_done in RUN: no state change and no frame_done. A later real tb_done in TB completes the frame normally.
- Reset mid-frame: rst_n=0 after 2 accepts.
  - Required: all outputs 0 immediately and no tb_start.
  - Required: after release, a new 1-symbol frame produces pm_init, sm_wr_addr=0 and tb_len=1.
- Back-to-back frames: second frame's in_valid asserted during TB.
  - Required: in_ready stays 0 until after frame_done, and the second frame starts with pm_init and frame_err=0.

Source files
------------

// File: rtl/viterbi_pkg.sv
// Shared constants and types for the K=3, rate-1/2 Viterbi decoder control path.
package viterbi_pkg;

  localparam int K          = 3;
  localparam int NUM_STATES = 1 << (K - 1);
  localparam int SYM_W      = 2;
  localparam int PM_W       = 8;

  // Path-metric reset value for every trellis state other than state 0.
  localparam logic [PM_W-1:0] PM_INIT_MAX = '1;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    RUN,
    DRAIN,
    TB,
    DONE
  } ctrl_state_t;

  // Value the path-metric unit loads into trellis state `state` on pm_init.
  function automatic logic [PM_W-1:0] pm_init_value(input int unsigned state);
    return (state == 0 || state >= NUM_STATES) ? '0 : PM_INIT_MAX;
  endfunction

endpackage

// File: rtl/viterbi_sm_ptr.sv
// Survivor-memory write pointer and per-frame symbol counter.
module viterbi_sm_ptr #(
  parameter int SM_AW = 5,
  parameter int LEN_W = SM_AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             ptr_inc_i,
  input  logic             cnt_inc_i,
  output logic [SM_AW-1:0] ptr_o,
  output logic [LEN_W-1:0] cnt_o,
  output logic             cnt_full_o
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2 ** SM_AW);

  logic [SM_AW-1:0] ptr_q, ptr_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: every path assigns ptr_d/cnt_d first, so no latch is inferred.
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      ptr_d = '0;
      cnt_d = '0;
    end else begin
      if (ptr_inc_i) ptr_d = ptr_q + 1'b1;  // wraps modulo 2^SM_AW
      if (cnt_inc_i) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      // NOTE: non-blocking so both registers update from pre-edge values.
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  assign ptr_o      = ptr_q;
  assign cnt_o      = cnt_q;
  // The next accepted symbol is the last one the survivor memory can hold.
  assign cnt_full_o = (cnt_q == MAX_LEN - 1'b1);

endmodule

// File: rtl/viterbi_ctrl.sv
// Frame sequencer: symbol intake, ACS strobing, survivor addressing and traceback hand-off.
module viterbi_ctrl
  import viterbi_pkg::*;
#(
  parameter int SM_AW = 5,
  parameter int LEN_W = SM_AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SYM_W-1:0] in_sym,
  input  logic             in_last,
  output logic [SYM_W-1:0] bm_sym,
  output logic             pm_init,
  output logic             acs_en,
  output logic [SM_AW-1:0] sm_wr_addr,
  output logic             tb_start,
  output logic [LEN_W-1:0] tb_len,
  output logic [SM_AW-1:0] tb_addr,
  input  logic             tb_done,
  output logic             frame_done,
  output logic             frame_err
);

  ctrl_state_t      state_q;
  logic             in_ready_q;
  logic [SYM_W-1:0] bm_sym_q;
  logic             pm_init_q;
  logic             acs_en_q;
  logic             tb_start_q;
  logic [LEN_W-1:0] tb_len_q;
  logic [SM_AW-1:0] tb_addr_q;
  logic             frame_done_q;
  logic             frame_err_q;

  logic             accept;
  logic [SM_AW-1:0] wr_ptr;
  logic [LEN_W-1:0] sym_cnt;
  logic             cnt_full;

  assign accept = in_valid & in_ready_q;

  viterbi_sm_ptr #(
    .SM_AW(SM_AW),
    .LEN_W(LEN_W)
  ) u_sm_ptr (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (state_q == INIT),
    .ptr_inc_i (acs_en_q),
    .cnt_inc_i (accept),
    .ptr_o     (wr_ptr),
    .cnt_o     (sym_cnt),
    .cnt_full_o(cnt_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      in_ready_q   <= 1'b0;
      bm_sym_q     <= '0;
      pm_init_q    <= 1'b0;
      acs_en_q     <= 1'b0;
      tb_start_q   <= 1'b0;
      tb_len_q     <= '0;
      tb_addr_q    <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      pm_init_q    <= 1'b0;
      acs_en_q     <= 1'b0;
      tb_start_q   <= 1'b0;
      frame_done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // The waiting symbol stays on the bus; it is taken in RUN.
          if (in_valid) begin
            state_q     <= INIT;
            pm_init_q   <= 1'b1;
            frame_err_q <= 1'b0;
          end
        end
        INIT: begin
          state_q    <= RUN;
          in_ready_q <= 1'b1;
        end
        RUN: begin
          if (accept) begin
            bm_sym_q <= in_sym;
            acs_en_q <= 1'b1;
            if (in_last || cnt_full) begin
              state_q     <= DRAIN;
              in_ready_q  <= 1'b0;
              frame_err_q <= ~in_last;
            end
          end
        end
        DRAIN: begin
          // wr_ptr still addresses the final ACS write issued in this cycle.
          state_q    <= TB;
          tb_start_q <= 1'b1;
          tb_len_q   <= sym_cnt;
          tb_addr_q  <= wr_ptr;
        end
        TB: begin
          if (tb_done) begin
            state_q      <= DONE;
            frame_done_q <= 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign bm_sym     = bm_sym_q;
  assign pm_init    = pm_init_q;
  assign acs_en     = acs_en_q;
  assign sm_wr_addr = wr_ptr;
  assign tb_start   = tb_start_q;
  assign tb_len     = tb_len_q;
  assign tb_addr    = tb_addr_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_viterbi_ctrl.sv
// Self-checking bench for viterbi_ctrl with a frame-level reference model.
module tb_viterbi_ctrl;

  localparam int SM_AW = 2;
  localparam int LEN_W = SM_AW + 1;
  localparam int DEPTH = 1 << SM_AW;

  logic             clk      = 1'b0;
  logic             rst_n    = 1'b1;
  logic             in_valid = 1'b0;
  logic [1:0]       in_sym   = '0;
  logic             in_last  = 1'b0;
  logic             tb_done  = 1'b0;
  logic             in_ready, pm_init, acs_en, tb_start, frame_done, frame_err;
  logic [1:0]       bm_sym;
  logic [SM_AW-1:0] sm_wr_addr, tb_addr;
  logic [LEN_W-1:0] tb_len;

  int         vectors     = 0;
  int         miscompares = 0;
  logic [1:0] sym_a [8];
  bit         last_a[8];

  always #5 clk = ~clk;

  viterbi_ctrl #(.SM_AW(SM_AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sym    (in_sym),
    .in_last   (in_last),
    .bm_sym    (bm_sym),
    .pm_init   (pm_init),
    .acs_en    (acs_en),
    .sm_wr_addr(sm_wr_addr),
    .tb_start  (tb_start),
    .tb_len    (tb_len),
    .tb_addr   (tb_addr),
    .tb_done   (tb_done),
    .frame_done(frame_done),
    .frame_err (frame_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [14:0] all_outs();
    return {in_ready, bm_sym, pm_init, acs_en, sm_wr_addr, tb_start,
            tb_len, tb_addr, frame_done, frame_err};
  endfunction

  // Offers sym_a/last_a as one frame and checks everything the DUT does with it.
  task automatic run_frame(input bit gapped, input int tb_delay, input bit spurious,
                           input bit hold_after);
    int exp_n = DEPTH;
    bit exp_err = 1'b1;
    int acc_cyc[$];
    int cyc = 0, idx = 0, acc = 0, acs_seen = 0, pm_cnt = 0, tb_cnt = 0;
    int last_acc_cyc = -100, done_at = -1, done_drv = -100;
    bit acc_done = 0, gap_off = 0, finished = 0, run_seen = 0, spur_sent = 0;

    for (int i = 0; i < DEPTH; i++) begin
      if (last_a[i]) begin
        exp_n   = i + 1;
        exp_err = 1'b0;
        break;
      end
    end

    in_valid = 1'b1;
    in_sym   = sym_a[0];
    in_last  = last_a[0];
    tb_done  = 1'b0;
    while (!finished && cyc < 100) begin
      @(negedge clk);
      cyc++;
      tb_done = 1'b0;
      if (pm_init) begin
        pm_cnt++;
        check("pm_init_ready", in_ready, 0);
      end
      if (in_ready && !run_seen) begin
        run_seen = 1;
        check("err_clear", frame_err, 0);
      end
      if (acs_en) begin
        check("acs_extra", acs_seen < exp_n, 1);
        if (acs_seen < exp_n) begin
          check("acs_time", cyc, acc_cyc[acs_seen] + 1);
          check("bm_sym", bm_sym, sym_a[acs_seen]);
          check("wr_addr", sm_wr_addr, acs_seen % DEPTH);
        end
        acs_seen++;
      end else if (acs_seen > 0 && acs_seen <= exp_n) begin
        check("bm_hold", bm_sym, sym_a[acs_seen-1]);
      end
      if (acc_done) check("ready_low", in_ready, 0);
      if (tb_start) begin
        tb_cnt++;
        check("tb_latency", cyc, last_acc_cyc + 2);
        check("tb_len", tb_len, exp_n);
        check("tb_addr", tb_addr, (exp_n - 1) % DEPTH);
        check("frame_err", frame_err, exp_err);
        done_at = cyc + tb_delay;
      end
      if (frame_done) begin
        check("done_latency", cyc, done_drv + 1);
        finished = 1;
      end
      if (finished) break;

      if (cyc == done_at) begin
        tb_done  = 1'b1;
        done_drv = cyc;
      end else if (spurious && acc == 1 && !acc_done && !spur_sent) begin
        tb_done   = 1'b1;
        spur_sent = 1;
      end

      if (acc_done) begin
        in_valid = hold_after;
      end else if (gap_off) begin
        in_valid = 1'b0;
        in_last  = 1'($urandom_range(0, 1));
        gap_off  = 0;
      end else begin
        in_valid = 1'b1;
        in_sym   = sym_a[idx];
        in_last  = last_a[idx];
      end
      if (!acc_done && in_valid && in_ready) begin
        acc_cyc.push_back(cyc);
        idx++;
        acc++;
        gap_off = gapped;
        if (in_last || acc == DEPTH) begin
          acc_done     = 1;
          last_acc_cyc = cyc;
        end
      end
    end
    check("timeout", finished, 1);
    check("pm_count", pm_cnt, 1);
    check("acs_count", acs_seen, exp_n);
    check("tb_count", tb_cnt, 1);
  endtask

  task automatic set_frame(input logic [7:0] syms, input int last_pos);
    for (int i = 0; i < 8; i++) begin
      sym_a[i]  = (i < 4) ? syms[2*i +: 2] : 2'($urandom);
      last_a[i] = (i == last_pos);
    end
  endtask

  initial begin
    int  n, guard, p;
    bit  seen_tb;

    #2 rst_n = 1'b0;
    #1 check("reset_outs", all_outs(), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Single frame 00,01,10,11 with last on 11.
    set_frame(8'b11_10_01_00, 3);
    run_frame(0, 1, 0, 0);

    // Gapped input over three symbols.
    set_frame(8'b00_11_01_10, 2);
    run_frame(1, 0, 0, 0);

    // Overflow: five symbols offered, none marked last; the fifth stays offered.
    set_frame(8'b01_10_11_01, 8);
    run_frame(0, 2, 0, 1);
    check("err_sticky", frame_err, 1);

    // Spurious tb_done in RUN, entered directly behind the held overflow symbol.
    set_frame(8'b00_00_10_01, 1);
    run_frame(0, 2, 1, 0);

    // Back-to-back frames: second frame's valid raised while the first is in TB.
    set_frame(8'b00_01_11_10, 2);
    run_frame(0, 3, 0, 1);
    set_frame(8'b00_00_00_11, 0);
    run_frame(0, 0, 0, 0);

    // Reset in the middle of a frame.
    repeat (2) @(negedge clk);
    in_valid = 1'b1;
    in_sym   = 2'b01;
    in_last  = 1'b0;
    n        = 0;
    guard    = 0;
    while (n < 2 && guard < 50) begin
      @(negedge clk);
      guard++;
      if (in_ready && in_valid) n++;
    end
    check("rst_accepts", n, 2);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check("rst_mid_outs", all_outs(), 0);
    in_valid = 1'b0;
    seen_tb  = 0;
    repeat (3) begin
      @(negedge clk);
      if (tb_start) seen_tb = 1;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (tb_start) seen_tb = 1;
    end
    check("rst_no_tb", seen_tb, 0);
    set_frame(8'b00_00_00_10, 0);
    run_frame(0, 1, 0, 0);

    // Randomized frames: last position, gaps, traceback delay, spurious done.
    for (int f = 0; f < 12; f++) begin
      p = $urandom_range(0, DEPTH);
      set_frame(8'($urandom), (p < DEPTH) ? p : 8);
      run_frame(1'($urandom_range(0, 1)), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
